// File: rtl/bsg_tag_packet_tx_pkg.sv
// bsg_tag_packet_tx_pkg
//   Shared tag-line constants, request record and transmitter state type.
//   The optional master-reset preamble state exists only when
//   BSG_TAG_TX_PREAMBLE_EN is defined.
package bsg_tag_packet_tx_pkg;

    localparam int tag_els_gp               = 1024;
    localparam int tag_lg_els_gp            = $clog2(tag_els_gp);
    localparam int tag_max_payload_width_gp = 12;
    localparam int tag_lg_width_gp          = 4;

    // start bit + len field + data_not_reset + node id
    localparam int bsg_tag_tx_hdr_width_gp  = 1 + tag_lg_width_gp + 1 + tag_lg_els_gp;

    typedef struct packed {
        logic [tag_lg_els_gp-1:0]            node_id;
        logic                                data_not_reset;
        logic [tag_lg_width_gp-1:0]          len;
        logic [tag_max_payload_width_gp-1:0] payload;
    } bsg_tag_tx_req_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
`ifdef BSG_TAG_TX_PREAMBLE_EN
        ,
        ST_PRE  = 2'd3
`endif
    } bsg_tag_tx_state_e;

endpackage

// File: rtl/bsg_tag_tx_serializer.sv
// bsg_tag_tx_serializer
//   Parallel-in / serial-out shift register with a remaining-bit counter.
//   Ports:
//     clk_i, reset_i  clock, asynchronous active-high reset
//     load_i          capture data_i / count_i (has priority over shift_i)
//     data_i          frame, bit 0 goes out first
//     count_i         number of valid frame bits
//     shift_i         advance by one bit
//     bit_o           current serial bit (shift register bit 0)
//     last_o          the bit on bit_o is the final one of the frame
module bsg_tag_tx_serializer #(
    parameter int width_p     = 28,
    parameter int cnt_width_p = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [width_p-1:0]     data_i,
    input  logic [cnt_width_p-1:0] count_i,
    input  logic                   shift_i,
    output logic                   bit_o,
    output logic                   last_o
);

    logic [width_p-1:0]     shreg_q, shreg_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = count_i;
        end else if (shift_i) begin
            // zeros shift in, so the line idles low once the frame is out
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shreg_q[0];
    assign last_o = (cnt_q == cnt_width_p'(1));

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// bsg_tag_packet_tx
//   bsg_tag master-side serial transmitter. A request accepted on
//   v_i & ready_and_o is framed as start(1), len, data_not_reset, node_id,
//   payload[len-1:0] (every field LSB first), driven on tag_data_o, and
//   followed by one idle gap cycle.
//   Ports:
//     clk_i, reset_i    tag clock, asynchronous active-high reset
//     v_i, ready_and_o  request handshake
//     node_id_i, data_not_reset_i, len_i, payload_i  request fields
//     tag_data_o        serial tag line (flop driven)
//     busy_o            high whenever not idle
//   Build option: BSG_TAG_TX_PREAMBLE_EN adds a master-reset preamble of
//   preamble_len_p ones and one zero after reset release.
module bsg_tag_packet_tx
    import bsg_tag_packet_tx_pkg::*;
#(
    parameter int els_p               = tag_els_gp,
    parameter int lg_width_p          = tag_lg_width_gp,
    parameter int max_payload_width_p = tag_max_payload_width_gp,
    parameter int preamble_len_p      = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_and_o,
    input  logic [$clog2(els_p)-1:0]       node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_p-1:0]          len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           tag_data_o,
    output logic                           busy_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int hdr_w_lp  = 1 + lg_width_p + 1 + lg_els_lp;
    localparam int sr_w_lp   = hdr_w_lp + max_payload_width_p;
    localparam int cnt_w_lp  = $clog2(sr_w_lp + 1);
    localparam logic [lg_width_p-1:0] max_len_lp = lg_width_p'(max_payload_width_p);

    if (preamble_len_p < 1) begin : g_bad_preamble
        $error("preamble_len_p must be at least 1");
    end

    bsg_tag_tx_state_e              state_q;
    logic                           ready_q;
    logic                           busy_q;
    logic [lg_width_p-1:0]          len_clamped;
    logic [max_payload_width_p-1:0] payload_masked;
    logic [sr_w_lp-1:0]             frame;
    logic [cnt_w_lp-1:0]            frame_bits;
    logic                           accept;
    logic                           ser_bit;
    logic                           ser_last;

    always_comb begin
        len_clamped    = (len_i > max_len_lp) ? max_len_lp : len_i;
        payload_masked = '0;
        for (int unsigned i = 0; i < max_payload_width_p; i++) begin
            payload_masked[i] = payload_i[i] & (i < 32'(len_clamped));
        end
        frame      = {payload_masked, node_id_i, data_not_reset_i, len_clamped, 1'b1};
        frame_bits = cnt_w_lp'(hdr_w_lp) + cnt_w_lp'(len_clamped);
    end

    assign accept = v_i & ready_q;

    bsg_tag_tx_serializer #(
        .width_p     (sr_w_lp),
        .cnt_width_p (cnt_w_lp)
    ) serializer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (accept),
        .data_i  (frame),
        .count_i (frame_bits),
        .shift_i (state_q == ST_SEND),
        .bit_o   (ser_bit),
        .last_o  (ser_last)
    );

`ifdef BSG_TAG_TX_PREAMBLE_EN
    localparam int pre_w_lp = $clog2(preamble_len_p + 1);
    logic [pre_w_lp-1:0] pre_cnt_q;
    logic                pre_line_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
`ifdef BSG_TAG_TX_PREAMBLE_EN
            state_q    <= ST_PRE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            pre_cnt_q  <= '0;
            pre_line_q <= 1'b0;
`else
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_SEND;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (ser_last) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
`ifdef BSG_TAG_TX_PREAMBLE_EN
                ST_PRE: begin
                    // preamble_len_p ones, then the line drops for the
                    // first idle cycle which doubles as the trailing zero
                    if (pre_cnt_q == pre_w_lp'(preamble_len_p)) begin
                        pre_line_q <= 1'b0;
                        state_q    <= ST_IDLE;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        pre_line_q <= 1'b1;
                        pre_cnt_q  <= pre_cnt_q + pre_w_lp'(1);
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BSG_TAG_TX_PREAMBLE_EN
    assign tag_data_o = ser_bit | pre_line_q;
`else
    assign tag_data_o = ser_bit;
`endif
    assign ready_and_o = ready_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// tb_bsg_tag_packet_tx
//   Randomized scoreboard bench for bsg_tag_packet_tx (default build).
//   The driver pushes the expected serial stream for each accepted request;
//   a negedge monitor pops one bit per cycle and otherwise expects idle.
module tb_bsg_tag_packet_tx;
    import bsg_tag_packet_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_and_o;
    logic [9:0]  node_id_i;
    logic        data_not_reset_i;
    logic [3:0]  len_i;
    logic [11:0] payload_i;
    logic        tag_data_o;
    logic        busy_o;

    bsg_tag_packet_tx #(
        .els_p               (1024),
        .lg_width_p          (4),
        .max_payload_width_p (12),
        .preamble_len_p      (32)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .node_id_i        (node_id_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit exp_q[$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference framing: start, clamped len, dnr, node id, payload, then gap.
    task automatic push_expected(input bsg_tag_tx_req_s r);
        int unsigned lc;
        lc = (r.len > 12) ? 12 : int'(r.len);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++)  exp_q.push_back(bit'((lc >> i) & 1));
        exp_q.push_back(r.data_not_reset);
        for (int i = 0; i < 10; i++) exp_q.push_back(bit'((r.node_id >> i) & 1));
        for (int i = 0; i < int'(lc); i++) exp_q.push_back(bit'((r.payload >> i) & 1));
        exp_q.push_back(1'b0);
    endtask

    task automatic send(input bsg_tag_tx_req_s r, input bit hold);
        int waited;
        @(negedge clk);
        v_i              = 1'b1;
        node_id_i        = r.node_id;
        data_not_reset_i = r.data_not_reset;
        len_i            = r.len;
        payload_i        = r.payload;
        waited = 0;
        while (ready_and_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", ready_and_o, 1'b1);
        if (ready_and_o !== 1'b1) begin
            v_i = 1'b0;
            return;
        end
        @(posedge clk);
        push_expected(r);
        #1;
        // inputs must not matter once accepted
        node_id_i        = 10'($urandom);
        data_not_reset_i = 1'($urandom);
        len_i            = 4'($urandom);
        payload_i        = 12'($urandom);
        if (!hold) v_i = 1'b0;
    endtask

    function automatic bsg_tag_tx_req_s rand_req();
        bsg_tag_tx_req_s r;
        r.node_id        = 10'($urandom);
        r.data_not_reset = 1'($urandom);
        r.len            = 4'($urandom);
        r.payload        = 12'($urandom);
        return r;
    endfunction

    initial begin : monitor
        bit b;
        forever begin
            @(negedge clk);
            if (mon_en && !reset_i) begin
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("tag_data", tag_data_o, b);
                    check("busy_active", busy_o, 1'b1);
                    check("ready_active", ready_and_o, 1'b0);
                end else begin
                    check("tag_idle", tag_data_o, 1'b0);
                    check("busy_idle", busy_o, 1'b0);
                    check("ready_idle", ready_and_o, 1'b1);
                end
            end
        end
    end

    initial begin : stimulus
        bsg_tag_tx_req_s r;
        int waited;
        reset_i          = 1'b1;
        v_i              = 1'b0;
        node_id_i        = '0;
        data_not_reset_i = 1'b0;
        len_i            = '0;
        payload_i        = '0;
        #1;
        check("reset_tag", tag_data_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_ready", ready_and_o, 1'b1);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1 mon_en = 1'b1;

        r = '{node_id: 10'd5, data_not_reset: 1'b1, len: 4'd2, payload: 12'h002};
        send(r, 1'b0);
        r = '{node_id: 10'd1023, data_not_reset: 1'b0, len: 4'd0, payload: 12'hFFF};
        send(r, 1'b0);
        r = '{node_id: 10'd300, data_not_reset: 1'b1, len: 4'd15, payload: 12'hABC};
        send(r, 1'b1);
        r = '{node_id: 10'd77, data_not_reset: 1'b1, len: 4'd7, payload: 12'hF5A};
        send(r, 1'b1);
        r = '{node_id: 10'd512, data_not_reset: 1'b0, len: 4'd12, payload: 12'h801};
        send(r, 1'b0);

        // abort mid-payload with the line high
        r = '{node_id: 10'd0, data_not_reset: 1'b1, len: 4'd12, payload: 12'hFFF};
        send(r, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        mon_en  = 1'b0;
        reset_i = 1'b1;
        #1;
        check("abort_tag", tag_data_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_ready", ready_and_o, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1 mon_en = 1'b1;

        r = '{node_id: 10'd683, data_not_reset: 1'b1, len: 4'd5, payload: 12'h015};
        send(r, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r = rand_req();
            send(r, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        v_i = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("drain", exp_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
